// File: rtl/microwave_timer_ctrl.sv
// Cooking sequencer for the microwave countdown timer: owns the FSM, derives the
// 1 s count tick and drives the digit-chain strobes, magnetron enable and alarm.
module microwave_timer_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int ALARM_TICKS = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic       timer_zero,
    output logic       tim_loadn,
    output logic       tim_clearn,
    output logic       tim_enable,
    output logic       mag_on,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e        st_q;
    logic [PW-1:0] presc;
    logic [AW-1:0] alarm_cnt;
    logic          presc_wrap;
    logic          can_cook;

    assign state      = st_q;
    assign presc_wrap = (presc == PW'(TICK_DIV - 1));
    assign can_cook   = start && door_closed && !timer_zero;

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            st_q       <= IDLE;
            presc      <= '0;
            alarm_cnt  <= '0;
            tim_loadn  <= 1'b1;
            tim_clearn <= 1'b0;
            tim_enable <= 1'b0;
            mag_on     <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            tim_loadn  <= 1'b1;
            tim_clearn <= 1'b1;
            tim_enable <= 1'b0;
            case (st_q)
                IDLE: begin
                    if (key_valid) begin
                        st_q      <= SET;
                        tim_loadn <= 1'b0;
                    end else if (can_cook) begin
                        st_q   <= COOK;
                        mag_on <= 1'b1;
                    end
                end
                SET: begin
                    // Clear beats load, load beats start.
                    if (stop) begin
                        st_q       <= IDLE;
                        tim_clearn <= 1'b0;
                    end else if (key_valid) begin
                        tim_loadn <= 1'b0;
                    end else if (can_cook) begin
                        st_q   <= COOK;
                        mag_on <= 1'b1;
                    end
                end
                COOK: begin
                    if (timer_zero) begin
                        st_q      <= DONE;
                        mag_on    <= 1'b0;
                        alarm     <= 1'b1;
                        presc     <= '0;
                        alarm_cnt <= '0;
                    end else if (!door_closed || stop) begin
                        // Prescaler frozen on the exit cycle so resume neither loses nor gains a tick.
                        st_q   <= PAUSE;
                        mag_on <= 1'b0;
                    end else if (presc_wrap) begin
                        presc      <= '0;
                        tim_enable <= 1'b1;  // timer_zero already known low here
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        st_q       <= IDLE;
                        tim_clearn <= 1'b0;
                        presc      <= '0;
                    end else if (start && door_closed) begin
                        st_q   <= COOK;
                        mag_on <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop) begin
                        st_q      <= IDLE;
                        alarm     <= 1'b0;
                        presc     <= '0;
                        alarm_cnt <= '0;
                    end else if (presc_wrap) begin
                        presc <= '0;
                        if (alarm_cnt == AW'(ALARM_TICKS - 1)) begin
                            st_q      <= IDLE;
                            alarm     <= 1'b0;
                            alarm_cnt <= '0;
                        end else begin
                            alarm_cnt <= alarm_cnt + AW'(1);
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    st_q      <= IDLE;
                    mag_on    <= 1'b0;
                    alarm     <= 1'b0;
                    presc     <= '0;
                    alarm_cnt <= '0;
                end
            endcase
        end
    end

endmodule
